// File: rtl/mmu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : mmu_pkg                                                 |
// | Description: Shared types and default geometry for the chained-page  |
// |              MMU and the RAM wrapper.                                |
// | Revision   : 1.0 - initial clocked translator release                |
// +----------------------------------------------------------------------+
package mmu_pkg;

    // Default geometry, shared with the RAM wrapper
    localparam int c_MMU_SEG_W     = 9;
    localparam int c_MMU_PAGE_SIZE = 151;

    // Cache fields are stored at a fixed maximum width so the struct can live
    // here independent of the translator's parameters
    localparam int c_MMU_CACHE_SEG_W   = 16;
    localparam int c_MMU_CACHE_LPAGE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        RESP = 2'd2
    } mmu_state_e;

    typedef struct packed {
        logic                           valid;
        logic [c_MMU_CACHE_SEG_W-1:0]   start_seg;
        logic [c_MMU_CACHE_LPAGE_W-1:0] lpage;
        logic [c_MMU_CACHE_SEG_W-1:0]   seg;
    } mmu_cache_t;

endpackage
`default_nettype wire

// File: rtl/mmu_chain_tables.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : mmu_chain_tables                                        |
// | Description: Next-segment link table and logical-page table with     |
// |              one synchronous write port and async read of one entry. |
// | Revision   : 1.0 - initial clocked translator release                |
// +----------------------------------------------------------------------+
module mmu_chain_tables #(
    parameter int SEG_W   = 9,
    parameter int LPAGE_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [SEG_W-1:0]   i_wseg,
    input  logic [SEG_W-1:0]   i_wnext,
    input  logic [LPAGE_W-1:0] i_wlpage,
    input  logic [SEG_W-1:0]   i_rseg,
    output logic [SEG_W-1:0]   o_chain,
    output logic [LPAGE_W-1:0] o_lpage
);

    localparam int c_DEPTH = 2**SEG_W;

    logic [SEG_W-1:0]   r_chain [c_DEPTH];
    logic [LPAGE_W-1:0] r_lpage [c_DEPTH];

    // Reset leaves every segment as its own chain end; segment 0 holds page 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_chain[i] <= SEG_W'(i);
                r_lpage[i] <= (i == 0) ? LPAGE_W'(1) : '0;
            end
        end else if (i_we) begin
            r_chain[i_wseg] <= i_wnext;
            r_lpage[i_wseg] <= i_wlpage;
        end
    end

    assign o_chain = r_chain[i_rseg];
    assign o_lpage = r_lpage[i_rseg];

endmodule
`default_nettype wire

// File: rtl/mmu_chain_translator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : mmu_chain_translator                                    |
// | Description: Clocked chained-page MMU. Walks the per-process segment |
// |              chain one hop per cycle, with a one-entry cache, fault  |
// |              reporting and a table configuration port.               |
// | Revision   : 1.0 - initial clocked translator release                |
// +----------------------------------------------------------------------+
module mmu_chain_translator
    import mmu_pkg::*;
#(
    parameter int LADDR_W   = 16,
    parameter int PADDR_W   = 17,
    parameter int SEG_W     = c_MMU_SEG_W,
    parameter int PAGE_SIZE = c_MMU_PAGE_SIZE,
    parameter int LPAGE_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [LADDR_W-1:0] req_laddr,
    input  logic [SEG_W-1:0]   req_start_seg,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [PADDR_W-1:0] rsp_paddr,
    output logic               rsp_fault,
    input  logic               cfg_we,
    output logic               cfg_ready,
    input  logic [SEG_W-1:0]   cfg_seg,
    input  logic [SEG_W-1:0]   cfg_next,
    input  logic [LPAGE_W-1:0] cfg_lpage,
    input  logic               flush
);

    localparam logic [31:0] c_PAGE_SIZE_32 = 32'(PAGE_SIZE);

    generate
        if ((2**SEG_W) * PAGE_SIZE > 2**PADDR_W) begin : g_chk_range
            $error("mmu_chain_translator: segments do not fit in PADDR_W");
        end
        if (SEG_W > c_MMU_CACHE_SEG_W || LPAGE_W > c_MMU_CACHE_LPAGE_W) begin : g_chk_cache
            $error("mmu_chain_translator: cache fields too narrow");
        end
    endgenerate

    mmu_state_e         r_state,  w_state_nxt;
    logic [SEG_W-1:0]   r_cur,    w_cur_nxt;
    logic [SEG_W-1:0]   r_start,  w_start_nxt;
    logic [SEG_W-1:0]   r_hops,   w_hops_nxt;
    logic [LPAGE_W-1:0] r_lp,     w_lp_nxt;
    logic [PADDR_W-1:0] r_off,    w_off_nxt;
    logic [PADDR_W-1:0] r_paddr,  w_paddr_nxt;
    logic               r_fault,  w_fault_nxt;
    mmu_cache_t         r_cache,  w_cache_nxt;

    logic [SEG_W-1:0]   w_rd_seg;
    logic [SEG_W-1:0]   w_tbl_chain;
    logic [LPAGE_W-1:0] w_tbl_lpage;
    logic               w_cfg_wr;
    logic [LPAGE_W-1:0] w_req_lp;
    logic [PADDR_W-1:0] w_req_off;
    logic               w_hit;

    function automatic logic [PADDR_W-1:0] f_phys(input logic [SEG_W-1:0] seg,
                                                  input logic [PADDR_W-1:0] off);
        return PADDR_W'(seg) * PADDR_W'(PAGE_SIZE) + off;
    endfunction

    // In IDLE the table is read at the start segment to fetch the first link
    assign w_rd_seg  = (r_state == IDLE) ? req_start_seg : r_cur;
    assign cfg_ready = (r_state != WALK);
    assign w_cfg_wr  = cfg_we && cfg_ready;
    assign w_req_lp  = LPAGE_W'(32'(req_laddr) / c_PAGE_SIZE_32);
    assign w_req_off = PADDR_W'(32'(req_laddr) % c_PAGE_SIZE_32);
    assign w_hit     = r_cache.valid
                    && (r_cache.start_seg == c_MMU_CACHE_SEG_W'(req_start_seg))
                    && (r_cache.lpage == c_MMU_CACHE_LPAGE_W'(w_req_lp));
    assign rsp_paddr = r_paddr;
    assign rsp_fault = r_fault;

    mmu_chain_tables #(
        .SEG_W   (SEG_W),
        .LPAGE_W (LPAGE_W)
    ) u_tables (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_cfg_wr),
        .i_wseg   (cfg_seg),
        .i_wnext  (cfg_next),
        .i_wlpage (cfg_lpage),
        .i_rseg   (w_rd_seg),
        .o_chain  (w_tbl_chain),
        .o_lpage  (w_tbl_lpage)
    );

    // State, walk datapath and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cur   <= '0;
            r_start <= '0;
            r_hops  <= '0;
            r_lp    <= '0;
            r_off   <= '0;
            r_paddr <= '0;
            r_fault <= 1'b0;
            r_cache <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_start <= w_start_nxt;
            r_hops  <= w_hops_nxt;
            r_lp    <= w_lp_nxt;
            r_off   <= w_off_nxt;
            r_paddr <= w_paddr_nxt;
            r_fault <= w_fault_nxt;
            r_cache <= w_cache_nxt;
        end
    end

    // Next-state, handshakes, walk step and cache update
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_start_nxt = r_start;
        w_hops_nxt  = r_hops;
        w_lp_nxt    = r_lp;
        w_off_nxt   = r_off;
        w_paddr_nxt = r_paddr;
        w_fault_nxt = r_fault;
        w_cache_nxt = r_cache;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_lp_nxt    = w_req_lp;
                    w_off_nxt   = w_req_off;
                    w_start_nxt = req_start_seg;
                    w_fault_nxt = 1'b0;
                    if (w_req_lp == '0) begin
                        w_paddr_nxt = f_phys(req_start_seg, w_req_off);
                        w_state_nxt = RESP;
                    end else if (w_hit) begin
                        w_paddr_nxt = f_phys(SEG_W'(r_cache.seg), w_req_off);
                        w_state_nxt = RESP;
                    end else begin
                        w_cur_nxt   = w_tbl_chain;
                        w_hops_nxt  = SEG_W'(1);
                        w_state_nxt = WALK;
                    end
                end
            end
            WALK: begin
                if (w_tbl_lpage == r_lp) begin
                    w_paddr_nxt           = f_phys(r_cur, r_off);
                    w_fault_nxt           = 1'b0;
                    w_cache_nxt.valid     = 1'b1;
                    w_cache_nxt.start_seg = c_MMU_CACHE_SEG_W'(r_start);
                    w_cache_nxt.lpage     = c_MMU_CACHE_LPAGE_W'(r_lp);
                    w_cache_nxt.seg       = c_MMU_CACHE_SEG_W'(r_cur);
                    w_state_nxt           = RESP;
                end else if (w_tbl_chain == r_cur || r_hops == {SEG_W{1'b1}}) begin
                    // Chain end or a walk long enough to prove a loop
                    w_paddr_nxt = '0;
                    w_fault_nxt = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_cur_nxt  = w_tbl_chain;
                    w_hops_nxt = r_hops + SEG_W'(1);
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // A table change or flush always wins over a same-cycle fill
        if (w_cfg_wr || flush) begin
            w_cache_nxt.valid = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmu_chain_translator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_mmu_chain_translator                                 |
// | Description: Self-checking bench: vector table, hand-written corner  |
// |              sequences and random traffic against a chain model.     |
// | Revision   : 1.0 - initial clocked translator release                |
// +----------------------------------------------------------------------+
module tb_mmu_chain_translator;

    localparam int LADDR_W = 16;
    localparam int PADDR_W = 17;
    localparam int SEG_W   = 9;
    localparam int LPAGE_W = 12;
    localparam int PS      = 151;
    localparam int DEPTH   = 512;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [LADDR_W-1:0] req_laddr = '0;
    logic [SEG_W-1:0]   req_start_seg = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [PADDR_W-1:0] rsp_paddr;
    logic               rsp_fault;
    logic               cfg_we = 1'b0;
    logic               cfg_ready;
    logic [SEG_W-1:0]   cfg_seg = '0;
    logic [SEG_W-1:0]   cfg_next = '0;
    logic [LPAGE_W-1:0] cfg_lpage = '0;
    logic               flush = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int m_chain [DEPTH];
    int m_lpage [DEPTH];
    bit mc_v;
    int mc_start, mc_lp, mc_seg;

    mmu_chain_translator dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_laddr     (req_laddr),
        .req_start_seg (req_start_seg),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_paddr     (rsp_paddr),
        .rsp_fault     (rsp_fault),
        .cfg_we        (cfg_we),
        .cfg_ready     (cfg_ready),
        .cfg_seg       (cfg_seg),
        .cfg_next      (cfg_next),
        .cfg_lpage     (cfg_lpage),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_chain[i] = i;
            m_lpage[i] = (i == 0) ? 1 : 0;
        end
        mc_v = 1'b0;
    endfunction

    // Follow the chain from the start segment looking for the logical page
    function automatic void model(input int start, input int laddr,
                                  output int p, output int f, output int l);
        int lp, off, cur;
        lp  = laddr / PS;
        off = laddr % PS;
        p = 0; f = 0; l = 1;
        if (lp == 0) begin
            p = start * PS + off;
        end else if (mc_v && mc_start == start && mc_lp == lp) begin
            p = mc_seg * PS + off;
        end else begin
            f = 1; l = DEPTH;
            cur = m_chain[start];
            for (int k = 1; k < DEPTH; k++) begin
                if (m_lpage[cur] == lp) begin
                    p = cur * PS + off; f = 0; l = k + 1;
                    mc_v = 1'b1; mc_start = start; mc_lp = lp; mc_seg = cur;
                    break;
                end
                if (m_chain[cur] == cur) begin
                    l = k + 1;
                    break;
                end
                cur = m_chain[cur];
            end
        end
    endfunction

    task automatic cfg_write(input int seg, input int nxt, input int lpg);
        int waitc;
        @(negedge clk);
        cfg_we = 1'b1; cfg_seg = SEG_W'(seg); cfg_next = SEG_W'(nxt); cfg_lpage = LPAGE_W'(lpg);
        waitc = 0;
        while (!cfg_ready && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 2000) chk("cfg_timeout", 1, 0);
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
        m_chain[seg] = nxt;
        m_lpage[seg] = lpg;
        mc_v = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        mc_v = 1'b0;
    endtask

    // Wait (bounded) for a response and return its latency from acceptance
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_req(input string nm, input int start, input int laddr,
                          input int ep, input int ef, input int el);
        int lat, mp, mf, ml;
        model(start, laddr, mp, mf, ml);
        @(negedge clk);
        req_valid = 1'b1; req_laddr = LADDR_W'(laddr); req_start_seg = SEG_W'(start);
        chk({nm, "_req_ready"}, int'(req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat);
        chk({nm, "_latency"}, lat, el);
        chk({nm, "_paddr"}, int'(rsp_paddr), ep);
        chk({nm, "_fault"}, int'(rsp_fault), ef);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        string nm;
        int    start;
        int    laddr;
        int    paddr;
        int    fault;
        int    lat;
    } vec_t;

    initial begin
        vec_t vecs [8];
        int   lat, p, f, l, op, s, a;

        vecs[0] = '{"page0",       0, 100, 100, 0, 1};
        vecs[1] = '{"first_hop",   0, 463, 765, 0, 2};
        vecs[2] = '{"third_hop",   0, 158, 158, 0, 4};
        vecs[3] = '{"cache_hit",   0, 158, 158, 0, 1};
        vecs[4] = '{"cache_hit2",  0, 151, 151, 0, 1};
        vecs[5] = '{"second_hop",  0, 307, 307, 0, 3};
        vecs[6] = '{"page0_seg5",  5, 100, 855, 0, 1};
        vecs[7] = '{"chain_end",   0, 604, 0,   1, 4};

        model_reset();
        #12;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_req_ready", int'(req_ready), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_paddr", int'(rsp_paddr), 0);
        chk("reset_rsp_fault", int'(rsp_fault), 0);
        chk("reset_cfg_ready", int'(cfg_ready), 1);

        // Chain 0 -> 5 -> 2 -> 1 -> 1
        cfg_write(0, 5, 1);
        cfg_write(5, 2, 3);
        cfg_write(2, 1, 2);
        cfg_write(1, 1, 1);

        foreach (vecs[i])
            do_req(vecs[i].nm, vecs[i].start, vecs[i].laddr, vecs[i].paddr, vecs[i].fault, vecs[i].lat);

        do_flush();
        do_req("after_flush", 0, 158, 158, 0, 4);

        // Loop 5 <-> 2 must end in a fault after the full hop budget
        cfg_write(2, 5, 2);
        do_req("loop", 0, 604, 0, 1, 512);
        cfg_write(2, 1, 2);

        // Backpressure: response held, no new request taken
        do_req("bp_setup", 0, 463, 765, 0, 2);
        do_flush();
        @(negedge clk);
        req_valid = 1'b1; req_laddr = 16'd463; req_start_seg = '0;
        @(posedge clk);
        @(negedge clk);
        req_laddr = 16'd100;
        wait_rsp(lat);
        chk("bp_latency", lat, 2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_paddr", int'(rsp_paddr), 765);
            chk("bp_fault", int'(rsp_fault), 0);
            chk("bp_req_ready", int'(req_ready), 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_done_valid", int'(rsp_valid), 0);
        chk("bp_done_ready", int'(req_ready), 1);
        model(0, 463, p, f, l);

        // Table write attempted during WALK is refused
        do_flush();
        @(negedge clk);
        req_valid = 1'b1; req_laddr = 16'd158; req_start_seg = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cfg_we = 1'b1; cfg_seg = 9'd1; cfg_next = 9'd1; cfg_lpage = 12'd7;
        chk("walk_cfg_ready", int'(cfg_ready), 0);
        @(negedge clk);
        chk("walk_cfg_ready2", int'(cfg_ready), 0);
        cfg_we = 1'b0;
        wait_rsp(lat);
        chk("walk_cfg_paddr", int'(rsp_paddr), 158);
        chk("walk_cfg_fault", int'(rsp_fault), 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        model(0, 158, p, f, l);
        do_flush();
        do_req("walk_cfg_table", 0, 158, 158, 0, 4);

        // Asynchronous reset in the middle of a walk
        @(negedge clk);
        req_valid = 1'b1; req_laddr = 16'd604; req_start_seg = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_no_rsp", int'(rsp_valid), 0);
        end
        do_req("rst_lpage0", 0, 158, 7, 0, 2);
        do_req("rst_chain5", 5, 158, 0, 1, 2);

        // Random traffic over a small segment pool
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                cfg_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 4));
            end else if (op == 3) begin
                do_flush();
            end else begin
                s = $urandom_range(0, 7);
                a = $urandom_range(0, 5 * PS - 1);
                begin
                    vec_t save_c;
                    bit sv; int ss, sl, sg;
                    sv = mc_v; ss = mc_start; sl = mc_lp; sg = mc_seg;
                    model(s, a, p, f, l);
                    mc_v = sv; mc_start = ss; mc_lp = sl; mc_seg = sg;
                    save_c.nm = "";
                end
                do_req("rand", s, a, p, f, l);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
